// File: rtl/serial_addsub_pkg.sv
// Shared types and arithmetic helpers for the digit-serial adder/subtractor.
package serial_addsub_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Container width for the generic digit adder; DIGIT_W must stay below this.
    localparam int DIGIT_MAX = 64;
    localparam int DW_SEL_W  = $clog2(DIGIT_MAX + 1);
    localparam logic [DIGIT_MAX:0] DIGIT_ONE = {{DIGIT_MAX{1'b0}}, 1'b1};

    function automatic int cnt_width(input int max_digits);
        return $clog2(max_digits + 1);
    endfunction

    // Adds the low w bits of a and b_eff plus cin; bit DIGIT_MAX of the
    // result carries the carry-out, the low w bits carry the digit.
    function automatic logic [DIGIT_MAX:0] digit_add(
        input logic [DIGIT_MAX-1:0] a,
        input logic [DIGIT_MAX-1:0] b_eff,
        input logic                 cin,
        input logic [DW_SEL_W-1:0]  w
    );
        logic [DIGIT_MAX:0] mask;
        logic [DIGIT_MAX:0] total;
        logic [DIGIT_MAX:0] r;
        mask  = (DIGIT_ONE << w) - DIGIT_ONE;
        total = ({1'b0, a} & mask) + ({1'b0, b_eff} & mask) + {{DIGIT_MAX{1'b0}}, cin};
        r     = total & mask;
        r[DIGIT_MAX] = total[w];
        return r;
    endfunction

endpackage

// File: rtl/serial_addsub_slice.sv
// Combinational DIGIT_W ripple slice: digit, carry-out, and the carry into the
// digit MSB (needed for signed overflow).
module serial_addsub_slice
    import serial_addsub_pkg::*;
#(
    parameter int DIGIT_W = 1
) (
    input  logic [DIGIT_W-1:0] a_i,
    input  logic [DIGIT_W-1:0] b_i,
    input  logic               cin_i,
    output logic [DIGIT_W-1:0] digit_o,
    output logic               cout_o,
    output logic               msb_cin_o
);

    localparam logic [DW_SEL_W-1:0] W_FULL = DW_SEL_W'(DIGIT_W);
    localparam logic [DW_SEL_W-1:0] W_LOW  = DW_SEL_W'(DIGIT_W - 1);

    logic [DIGIT_MAX:0] full;
    logic [DIGIT_MAX:0] low;
    logic               unused_bits;

    // The carry out of the low DIGIT_W-1 bits is the carry into the MSB.
    assign full = digit_add(DIGIT_MAX'(a_i), DIGIT_MAX'(b_i), cin_i, W_FULL);
    assign low  = digit_add(DIGIT_MAX'(a_i), DIGIT_MAX'(b_i), cin_i, W_LOW);

    assign digit_o   = full[DIGIT_W-1:0];
    assign cout_o    = full[DIGIT_MAX];
    assign msb_cin_o = low[DIGIT_MAX];

    assign unused_bits = ^{full[DIGIT_MAX-1:DIGIT_W], low[DIGIT_MAX-1:0]};

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor, LSB digit first, registered sum stream and
// end-of-operation result word; SERIAL_ADDSUB_RESULT_EN enables res/len_err.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int DIGIT_W    = 1,
    parameter int MAX_DIGITS = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          vld,
    input  logic [DIGIT_W-1:0]            a,
    input  logic [DIGIT_W-1:0]            b,
    input  logic                          sub,
    input  logic                          last,
    output logic                          sum_vld,
    output logic [DIGIT_W-1:0]            sum,
    output logic                          res_vld,
    output logic [MAX_DIGITS*DIGIT_W-1:0] res,
    output logic                          carry_out,
    output logic                          overflow,
    output logic                          len_err
);

    localparam int RES_W = MAX_DIGITS * DIGIT_W;

    state_t             state_q, state_d;
    logic               carry_q, carry_d;
    logic               sub_q, sub_d;
    logic               sum_vld_q, sum_vld_d;
    logic [DIGIT_W-1:0] sum_q, sum_d;
    logic               res_vld_q, res_vld_d;
    logic               carry_out_q, carry_out_d;
    logic               overflow_q, overflow_d;

    logic               first;
    logic               cin;
    logic               sub_eff;
    logic [DIGIT_W-1:0] b_eff;
    logic [DIGIT_W-1:0] digit;
    logic               cout;
    logic               msb_cin;

    // The first digit of an operation takes sub and carry-in from the inputs.
    assign first   = vld && (state_q == IDLE);
    assign cin     = first ? sub : carry_q;
    assign sub_eff = first ? sub : sub_q;
    assign b_eff   = sub_eff ? ~b : b;

    serial_addsub_slice #(
        .DIGIT_W (DIGIT_W)
    ) u_slice (
        .a_i       (a),
        .b_i       (b_eff),
        .cin_i     (cin),
        .digit_o   (digit),
        .cout_o    (cout),
        .msb_cin_o (msb_cin)
    );

    always_comb begin
        state_d     = state_q;
        carry_d     = carry_q;
        sub_d       = sub_q;
        sum_vld_d   = vld;
        sum_d       = sum_q;
        res_vld_d   = vld && last;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        if (vld) begin
            carry_d = cout;
            sub_d   = sub_eff;
            sum_d   = digit;
            if (last) begin
                state_d     = IDLE;
                carry_out_d = cout;
                overflow_d  = msb_cin ^ cout;
            end else begin
                state_d = BUSY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            carry_q     <= 1'b0;
            sub_q       <= 1'b0;
            sum_vld_q   <= 1'b0;
            sum_q       <= '0;
            res_vld_q   <= 1'b0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            carry_q     <= carry_d;
            sub_q       <= sub_d;
            sum_vld_q   <= sum_vld_d;
            sum_q       <= sum_d;
            res_vld_q   <= res_vld_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

    assign sum_vld   = sum_vld_q;
    assign sum       = sum_q;
    assign res_vld   = res_vld_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

`ifdef SERIAL_ADDSUB_RESULT_EN
    localparam int CNT_W = cnt_width(MAX_DIGITS);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] idx;
    logic [RES_W-1:0] acc_q, acc_d;
    logic [RES_W-1:0] res_q, res_d;
    logic [RES_W-1:0] word;
    logic             len_acc_q, len_acc_d;
    logic             len_err_q, len_err_d;
    logic             len_now;

    // The accumulator restarts from zero on the first digit, so a result that
    // completes can be followed by a new operation with no bubble.
    always_comb begin
        idx  = first ? '0 : cnt_q;
        word = first ? '0 : acc_q;
        for (int k = 0; k < MAX_DIGITS; k++) begin
            if (idx == CNT_W'(k)) begin
                word[k*DIGIT_W +: DIGIT_W] = digit;
            end
        end
        len_now   = (first ? 1'b0 : len_acc_q) | (idx >= CNT_W'(MAX_DIGITS));
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        len_acc_d = len_acc_q;
        res_d     = res_q;
        len_err_d = len_err_q;
        if (vld) begin
            cnt_d     = (idx == CNT_W'(MAX_DIGITS)) ? idx : idx + CNT_W'(1);
            acc_d     = word;
            len_acc_d = len_now;
            if (last) begin
                res_d     = word;
                len_err_d = len_now;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            len_acc_q <= 1'b0;
            res_q     <= '0;
            len_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            len_acc_q <= len_acc_d;
            res_q     <= res_d;
            len_err_q <= len_err_d;
        end
    end

    assign res     = res_q;
    assign len_err = len_err_q;
`else
    assign res     = {RES_W{1'b0}};
    assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: 1-bit digit instance for the multi-digit
// cases and a 4-bit digit instance for single-digit and back-to-back operations.
module tb_serial_addsub;

    logic        clk;
    logic        rst;

    logic        vld, a, b, sub, last;
    logic        sum_vld, sum, res_vld, carry_out, overflow, len_err;
    logic [7:0]  res;

    logic        vld4, sub4, last4;
    logic [3:0]  a4, b4, sum4;
    logic        sum_vld4, res_vld4, co4, ov4, le4;
    logic [31:0] res4;

    int vectors;
    int miscompares;

    serial_addsub #(.DIGIT_W(1), .MAX_DIGITS(8)) u_dut1 (
        .clk(clk), .rst(rst), .vld(vld), .a(a), .b(b), .sub(sub), .last(last),
        .sum_vld(sum_vld), .sum(sum), .res_vld(res_vld), .res(res),
        .carry_out(carry_out), .overflow(overflow), .len_err(len_err)
    );

    serial_addsub #(.DIGIT_W(4), .MAX_DIGITS(8)) u_dut4 (
        .clk(clk), .rst(rst), .vld(vld4), .a(a4), .b(b4), .sub(sub4), .last(last4),
        .sum_vld(sum_vld4), .sum(sum4), .res_vld(res_vld4), .res(res4),
        .carry_out(co4), .overflow(ov4), .len_err(le4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_res8(input logic [7:0] v);
`ifdef SERIAL_ADDSUB_RESULT_EN
        return v;
`else
        return v & 8'h00;
`endif
    endfunction

    function automatic logic exp_le(input logic v);
`ifdef SERIAL_ADDSUB_RESULT_EN
        return v;
`else
        return v & 1'b0;
`endif
    endfunction

    // Drives one operation on the 1-bit instance; sub is inverted after the
    // first digit to show it is only sampled at the start.
    task automatic run_op(input string tag, input logic [15:0] aw, input logic [15:0] bw,
                          input int n, input logic s, input bit gaps,
                          input logic [15:0] e_sum, input logic [7:0] e_res,
                          input logic e_co, input logic e_ov, input logic e_le);
        logic [15:0] got;
        int          seen;
        int          early;
        int          gap_bad;
        got = '0; seen = 0; early = 0; gap_bad = 0;
        for (int i = 0; i < n; i++) begin
            vld  = 1'b1;
            a    = aw[i];
            b    = bw[i];
            last = (i == n - 1);
            sub  = (i == 0) ? s : ~s;
            @(posedge clk); #1;
            if (sum_vld) begin
                got[i] = sum;
                seen++;
            end
            if (i < n - 1 && res_vld) early++;
            if (gaps && i < n - 1) begin
                vld  = 1'b0;
                last = 1'b1;
                a    = ~a;
                @(posedge clk); #1;
                if (sum_vld || res_vld) gap_bad++;
            end
        end
        chk({tag, "_res_vld"}, res_vld, 1'b1);
        chk({tag, "_sum_cnt"}, seen, n);
        chk({tag, "_early"}, early + gap_bad, 0);
        chk({tag, "_sum_stream"}, got, e_sum);
        chk({tag, "_res"}, res, exp_res8(e_res));
        chk({tag, "_carry"}, carry_out, e_co);
        chk({tag, "_ovf"}, overflow, e_ov);
        chk({tag, "_len_err"}, len_err, exp_le(e_le));
        vld = 1'b0; last = 1'b0; sub = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_pulse_end"}, {sum_vld, res_vld}, 2'b00);
        chk({tag, "_res_hold"}, res, exp_res8(e_res));
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst = 1'b1;
        vld = 1'b0; a = 1'b0; b = 1'b0; sub = 1'b0; last = 1'b0;
        vld4 = 1'b0; a4 = '0; b4 = '0; sub4 = 1'b0; last4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs1", {sum_vld, sum, res_vld, carry_out, overflow, len_err}, 6'b0);
        chk("rst_res1", res, 8'h00);
        chk("rst_outs4", {sum_vld4, sum4, res_vld4, co4, ov4, le4}, 9'b0);
        rst = 1'b0;

        run_op("add5a33", 16'h005A, 16'h0033, 8, 1'b0, 1'b0, 16'h008D, 8'h8D, 1'b0, 1'b1, 1'b0);
        run_op("sub1020", 16'h0010, 16'h0020, 8, 1'b1, 1'b0, 16'h00F0, 8'hF0, 1'b0, 1'b0, 1'b0);
        run_op("add_gaps", 16'h005A, 16'h0033, 8, 1'b0, 1'b1, 16'h008D, 8'h8D, 1'b0, 1'b1, 1'b0);

        // Abort after three digits; rst wins over a simultaneous vld&last.
        for (int i = 0; i < 3; i++) begin
            vld = 1'b1; a = 1'b1; b = 1'b1; last = 1'b0; sub = 1'b0;
            @(posedge clk); #1;
        end
        rst = 1'b1; last = 1'b1;
        @(posedge clk); #1;
        chk("abort_outs", {sum_vld, sum, res_vld, carry_out, overflow, len_err}, 6'b0);
        chk("abort_res", res, 8'h00);
        rst = 1'b0; vld = 1'b0; last = 1'b0;
        @(posedge clk); #1;
        chk("abort_no_pulse", res_vld, 1'b0);
        run_op("add0101", 16'h0001, 16'h0001, 8, 1'b0, 1'b0, 16'h0002, 8'h02, 1'b0, 1'b0, 1'b0);

        run_op("len10", 16'h03FF, 16'h0001, 10, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b1);

        // 4-bit digits: 7+1 in one digit, then 0x12-0x34 immediately after.
        vld4 = 1'b1; a4 = 4'h7; b4 = 4'h1; sub4 = 1'b0; last4 = 1'b1;
        @(posedge clk); #1;
        chk("w4_sum", {sum_vld4, sum4}, 5'h18);
        chk("w4_res_vld", res_vld4, 1'b1);
`ifdef SERIAL_ADDSUB_RESULT_EN
        chk("w4_res", res4, 32'h0000_0008);
`else
        chk("w4_res", res4, 32'h0000_0000);
`endif
        chk("w4_flags", {co4, ov4, le4}, 3'b010);
        a4 = 4'h2; b4 = 4'h4; sub4 = 1'b1; last4 = 1'b0;
        @(posedge clk); #1;
        chk("w4b_d0", {sum_vld4, sum4}, 5'h1E);
        chk("w4b_d0_pulse", res_vld4, 1'b0);
        a4 = 4'h1; b4 = 4'h3; sub4 = 1'b0; last4 = 1'b1;
        @(posedge clk); #1;
        chk("w4b_d1", {sum_vld4, sum4}, 5'h1D);
        chk("w4b_res_vld", res_vld4, 1'b1);
`ifdef SERIAL_ADDSUB_RESULT_EN
        chk("w4b_res", res4, 32'h0000_00DE);
`else
        chk("w4b_res", res4, 32'h0000_0000);
`endif
        chk("w4b_flags", {co4, ov4, le4}, 3'b000);
        vld4 = 1'b0; last4 = 1'b0;
        @(posedge clk); #1;
        chk("w4b_idle", {sum_vld4, res_vld4, sum4}, 6'h0D);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
